wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage that produces the single register-file write port (we/waddr/wdata) from two result sources.
- Source 1 is the ALU/CSR path: single-cycle results, valid/ready.
- Source 2 is the LSU load response: raw 64-bit bus data, aligned and sign/zero-extended here.
- Sits between EXE/MEM and the register file. Its registered write port also feeds the regfile's same-cycle read bypass.

Parameters:
- XLEN, 64, data width.
- RA_W, 5, register address width.
- ALU_Q_DEPTH, 2, ALU result queue entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_wen  in  1  result targets a GPR
- alu_rd  in  RA_W  destination register
- alu_data  in  XLEN  result value
- lsu_valid  in  1  load response offered
- lsu_ready  out  1  load response accepted this cycle
- lsu_rd  in  RA_W  destination register
- lsu_funct3  in  3  load type (LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110)
- lsu_addr_lo  in  3  byte offset of the load address
- lsu_rdata  in  XLEN  raw doubleword from the data bus
- we  out  1  regfile write enable
- waddr  out  RA_W  regfile write address
- wdata  out  XLEN  regfile write data
- commit  out  1  one instruction retired at writeback this cycle
- load_err  out  1  one-cycle pulse: illegal lsu_funct3 (111) accepted

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high:
  - we=0, waddr=0, wdata=0, commit=0, load_err=0.
  - Queue is emptied; arbiter state is IDLE.
  - alu_ready=0 and lsu_ready=0.
- Reset asserted mid-operation discards queued results; nothing is written on the following cycle.
- All outputs except alu_ready/lsu_ready are registered. Latency is 1 cycle from acceptance to we/waddr/wdata, unless a result waits in the queue.
- alu_ready = !rst && (queue count < ALU_Q_DEPTH). A push is allowed in the same cycle as a pop when the queue is full, only if ready was already high (no pop-through).
- Arbiter states:
  - IDLE (queue empty)
  - QUEUED (queue non-empty, not full)
  - DRAIN (queue full)
- Selection per cycle:
  - IDLE: lsu_valid wins (lsu_ready=1). If no load, alu_valid bypasses the queue directly to the output register. If a load wins, the ALU result is pushed into the queue.
  - QUEUED: the load wins over the queue head; the head drains on cycles without a load.
  - DRAIN: the queue head wins; lsu_ready=0 until the state leaves DRAIN. This guarantees ALU progress under back-to-back loads.
- Transitions:
  - IDLE→QUEUED on push without pop.
  - QUEUED→DRAIN on count reaching ALU_Q_DEPTH.
  - DRAIN→QUEUED after a pop without push.
  - QUEUED→IDLE when count reaches 0.
- Load formatting:
  - shifted = lsu_rdata >> (lsu_addr_lo*8).
  - LB/LH/LW sign-extend bit 7/15/31; LBU/LHU/LWU zero-extend; LD passes through.
  - Misalignment is not checked here; the LSU guarantees alignment.
- Illegal funct3 (111): the load is accepted. Next cycle: we=0, commit=1, load_err=1.
- rd==0, or an ALU result with alu_wen=0: we=0 and waddr=0 next cycle, commit=1. Unused wdata is driven 0.
- commit=1 exactly once per accepted result; at most one per cycle.
- No result is ever dropped or duplicated. Order within the ALU stream is preserved; ALU vs load ordering is arbitration-defined. Upstream hazard logic is responsible for WAW safety.

Decomposition:
- Shared defines: XLEN, RA_W, and the LB..LWU funct3 encodings, added to the existing global defines include. Arbiter state encodings stay local.
- One sub-module, load_align_ext: combinational shift plus extend (funct3, addr_lo, rdata → data, illegal).
- The queue is a small inline circular buffer in wb_arbiter.

Test Plan:
- Reset: rst=1 for 3 cycles while alu_valid=1 → we=0, wdata=0, alu_ready=0. First accept is at the cycle rst=0.
- ALU bypass: alu_valid, rd=5, data=0x1234 with no load → next cycle we=1, waddr=5, wdata=0x1234, commit=1.
- Load extend:
  - LB, addr_lo=3, rdata=0x00000000_80000000 → wdata=0xFFFFFFFF_FFFFFF80.
  - LBU same → 0x80.
  - LWU, addr_lo=4, rdata=0xDEADBEEF_00000000 → 0xDEADBEEF.
- Collision: load rd=7 and ALU rd=8 offered in the same cycle → cycle+1 writes x7, cycle+2 writes x8. Both commit.
- Drain fairness: lsu_valid held high while 3 ALU results are offered back-to-back → queue fills. lsu_ready=0 while DRAIN, the head is written, lsu_ready returns to 1. Final write order matches the arbitration rules.
- Corner cases:
  - ALU rd=0, data=0xFF → we=0, commit=1.
  - funct3=111 load → we=0, load_err=1 for one cycle.
  - Reset asserted with 2 queued entries → no writes afterwards.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and load funct3 encodings for the writeback stage.
package wb_arbiter_pkg;

  localparam int WB_XLEN = 64;
  localparam int WB_RA_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_align_ext.sv
// Load response formatter: shifts the raw doubleword down to the addressed
// byte lane and sign/zero-extends it to XLEN according to funct3.
module load_align_ext
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] shifted;

  // NOTE: every output of a combinational block gets a default first so
  // that no path through the case statement infers a latch.
  always_comb begin
    shifted   = rdata_i >> {addr_lo_i, 3'b000};
    data_o    = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   data_o = shifted;
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:  data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/CSR results and formatted load responses into
// the single registered register-file write port, queueing ALU results behind loads.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN        = WB_XLEN,
  parameter int RA_W        = WB_RA_W,
  parameter int ALU_Q_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic            alu_wen,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RA_W-1:0] lsu_rd,
  input  logic [2:0]      lsu_funct3,
  input  logic [2:0]      lsu_addr_lo,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            we,
  output logic [RA_W-1:0] waddr,
  output logic [XLEN-1:0] wdata,
  output logic            commit,
  output logic            load_err
);

  localparam int PTR_W = $clog2(ALU_Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(ALU_Q_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_QUEUED, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;

  logic             q_wen_q  [ALU_Q_DEPTH];
  logic [RA_W-1:0]  q_rd_q   [ALU_Q_DEPTH];
  logic [XLEN-1:0]  q_data_q [ALU_Q_DEPTH];

  logic            we_q, we_d;
  logic [RA_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            commit_q, commit_d;
  logic            load_err_q, load_err_d;

  logic [XLEN-1:0] load_data;
  logic            load_illegal;
  logic            lsu_fire, alu_fire, bypass, push, pop;

  load_align_ext #(.XLEN(XLEN)) u_align (
    .funct3_i  (lsu_funct3),
    .addr_lo_i (lsu_addr_lo),
    .rdata_i   (lsu_rdata),
    .data_o    (load_data),
    .illegal_o (load_illegal)
  );

  // Loads win unless the queue is full; the queue head then wins so ALU
  // results always make progress under a stream of loads.
  always_comb begin
    alu_ready = !rst && (count_q < Q_FULL);
    lsu_ready = !rst && (state_q != S_DRAIN);
    lsu_fire  = lsu_valid && lsu_ready;
    alu_fire  = alu_valid && alu_ready;
    pop       = !lsu_fire && (count_q != '0);
    bypass    = alu_fire && !lsu_fire && (count_q == '0);
    push      = alu_fire && !bypass;
  end

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (push) state_d = S_QUEUED;
      S_QUEUED: begin
        if (count_d == Q_FULL)   state_d = S_DRAIN;
        else if (count_d == '0)  state_d = S_IDLE;
      end
      S_DRAIN:  if (pop && !push) state_d = S_QUEUED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Unused write fields are forced to zero so the bypass path sees clean data.
  always_comb begin
    we_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    commit_d   = 1'b0;
    load_err_d = 1'b0;
    if (lsu_fire) begin
      commit_d = 1'b1;
      if (load_illegal) begin
        load_err_d = 1'b1;
      end else if (lsu_rd != '0) begin
        we_d    = 1'b1;
        waddr_d = lsu_rd;
        wdata_d = load_data;
      end
    end else if (pop) begin
      commit_d = 1'b1;
      if (q_wen_q[head_q] && (q_rd_q[head_q] != '0)) begin
        we_d    = 1'b1;
        waddr_d = q_rd_q[head_q];
        wdata_d = q_data_q[head_q];
      end
    end else if (bypass) begin
      commit_d = 1'b1;
      if (alu_wen && (alu_rd != '0)) begin
        we_d    = 1'b1;
        waddr_d = alu_rd;
        wdata_d = alu_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      commit_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      commit_q   <= commit_d;
      load_err_q <= load_err_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_wen_q[tail_q]  <= alu_wen;
      q_rd_q[tail_q]   <= alu_rd;
      q_data_q[tail_q] <= alu_data;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign commit   = commit_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: single-result vector table plus
// hand-written multi-cycle sequences for collisions, drain fairness and reset.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int XLEN = 64;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready, alu_wen;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [RA_W-1:0] lsu_rd;
  logic [2:0]      lsu_funct3, lsu_addr_lo;
  logic [XLEN-1:0] lsu_rdata;
  logic            we, commit, load_err;
  logic [RA_W-1:0] waddr;
  logic [XLEN-1:0] wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .RA_W(RA_W), .ALU_Q_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_wen     (alu_wen),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_funct3  (lsu_funct3),
    .lsu_addr_lo (lsu_addr_lo),
    .lsu_rdata   (lsu_rdata),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .commit      (commit),
    .load_err    (load_err)
  );

  typedef struct {
    logic            alu_v;
    logic            alu_wen;
    logic [RA_W-1:0] alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_v;
    logic [RA_W-1:0] lsu_rd;
    logic [2:0]      f3;
    logic [2:0]      lo;
    logic [XLEN-1:0] rdata;
    logic            e_we;
    logic [RA_W-1:0] e_waddr;
    logic [XLEN-1:0] e_wdata;
    logic            e_commit;
    logic            e_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_wen     = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_funct3  = '0;
    lsu_addr_lo = '0;
    lsu_rdata   = '0;
  endtask

  task automatic check_wb(input string tag, input logic e_we, input logic [RA_W-1:0] e_waddr,
                          input logic [XLEN-1:0] e_wdata, input logic e_commit, input logic e_err);
    check({tag, ".we"},       we,       e_we);
    check({tag, ".waddr"},    waddr,    e_waddr);
    check({tag, ".wdata"},    wdata,    e_wdata);
    check({tag, ".commit"},   commit,   e_commit);
    check({tag, ".load_err"}, load_err, e_err);
  endtask

  function automatic vec_t mk_alu(input logic wen, input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d,
                                  input logic [RA_W-1:0] e_rd, input logic [XLEN-1:0] e_d);
    vec_t v = '{default: '0};
    v.alu_v = 1'b1; v.alu_wen = wen; v.alu_rd = rd; v.alu_data = d;
    v.e_we = (e_rd != '0); v.e_waddr = e_rd; v.e_wdata = e_d; v.e_commit = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk_lsu(input logic [RA_W-1:0] rd, input logic [2:0] f3, input logic [2:0] lo,
                                  input logic [XLEN-1:0] rdata, input logic [RA_W-1:0] e_rd,
                                  input logic [XLEN-1:0] e_d, input logic e_err);
    vec_t v = '{default: '0};
    v.lsu_v = 1'b1; v.lsu_rd = rd; v.f3 = f3; v.lo = lo; v.rdata = rdata;
    v.e_we = (e_rd != '0); v.e_waddr = e_rd; v.e_wdata = e_d; v.e_commit = 1'b1; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[14];

  logic [RA_W-1:0] dr_rd  [8];
  logic [XLEN-1:0] dr_dat [8];
  logic            dr_ar  [8];
  logic            dr_lr  [8];

  initial begin
    vecs[0]  = mk_alu(1'b1, 5'd5, 64'h1234, 5'd5, 64'h1234);
    vecs[1]  = mk_lsu(5'd10, F3_LB,  3'd3, 64'h0000_0000_8000_0000, 5'd10, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    vecs[2]  = mk_lsu(5'd11, F3_LBU, 3'd3, 64'h0000_0000_8000_0000, 5'd11, 64'h80, 1'b0);
    vecs[3]  = mk_lsu(5'd12, F3_LWU, 3'd4, 64'hDEAD_BEEF_0000_0000, 5'd12, 64'hDEAD_BEEF, 1'b0);
    vecs[4]  = mk_lsu(5'd13, F3_LW,  3'd4, 64'hDEAD_BEEF_0000_0000, 5'd13, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
    vecs[5]  = mk_lsu(5'd14, F3_LH,  3'd2, 64'h0000_0000_8001_0000, 5'd14, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    vecs[6]  = mk_lsu(5'd15, F3_LHU, 3'd6, 64'h7FFF_0000_0000_0000, 5'd15, 64'h7FFF, 1'b0);
    vecs[7]  = mk_lsu(5'd16, F3_LD,  3'd0, 64'h0123_4567_89AB_CDEF, 5'd16, 64'h0123_4567_89AB_CDEF, 1'b0);
    vecs[8]  = mk_lsu(5'd17, F3_LB,  3'd7, 64'h7F00_0000_0000_0000, 5'd17, 64'h7F, 1'b0);
    vecs[9]  = mk_alu(1'b1, 5'd0, 64'hFF, 5'd0, 64'h0);
    vecs[10] = mk_alu(1'b0, 5'd9, 64'h55, 5'd0, 64'h0);
    vecs[11] = mk_lsu(5'd3,  3'b111, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'h0, 1'b1);
    vecs[12] = mk_lsu(5'd0,  F3_LD,  3'd0, 64'h1234, 5'd0, 64'h0, 1'b0);
    vecs[13] = '{default: '0};

    // Drain trace: loads L0..L3 -> x20..x23, ALU A0..A2 -> x24..x26.
    dr_rd  = '{5'd20, 5'd21, 5'd24, 5'd22, 5'd25, 5'd23, 5'd26, 5'd0};
    dr_dat = '{64'h100, 64'h101, 64'h200, 64'h102, 64'h201, 64'h103, 64'h202, 64'h0};
    dr_ar  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    dr_lr  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset held with an ALU result offered: nothing accepted, nothing written.
    idle_inputs();
    rst = 1'b1;
    alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd1; alu_data = 64'hAA;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d.we", c),        we,        1'b0);
      check($sformatf("rst%0d.wdata", c),     wdata,     64'h0);
      check($sformatf("rst%0d.commit", c),    commit,    1'b0);
      check($sformatf("rst%0d.alu_ready", c), alu_ready, 1'b0);
      check($sformatf("rst%0d.lsu_ready", c), lsu_ready, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release.alu_ready", alu_ready, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    check_wb("first_accept", 1'b1, 5'd1, 64'hAA, 1'b1, 1'b0);

    // Single-result vectors from the idle state.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      alu_valid = vecs[i].alu_v;  alu_wen = vecs[i].alu_wen;
      alu_rd = vecs[i].alu_rd;    alu_data = vecs[i].alu_data;
      lsu_valid = vecs[i].lsu_v;  lsu_rd = vecs[i].lsu_rd;
      lsu_funct3 = vecs[i].f3;    lsu_addr_lo = vecs[i].lo;
      lsu_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d.alu_ready", i), alu_ready, 1'b1);
      check($sformatf("vec%0d.lsu_ready", i), lsu_ready, 1'b1);
      @(posedge clk); #1;
      idle_inputs();
      check_wb($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
               vecs[i].e_commit, vecs[i].e_err);
    end

    // Collision: load to x7 wins, ALU x8 follows from the queue.
    @(negedge clk);
    alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd8; alu_data = 64'h88;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_funct3 = F3_LD; lsu_rdata = 64'h77;
    #1;
    check("coll.alu_ready", alu_ready, 1'b1);
    check("coll.lsu_ready", lsu_ready, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    check_wb("coll.c1", 1'b1, 5'd7, 64'h77, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_wb("coll.c2", 1'b1, 5'd8, 64'h88, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_wb("coll.c3", 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);

    // Drain fairness: loads held high while three ALU results stream in.
    begin
      int ai = 0;
      int li = 0;
      logic a_fire, l_fire;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        alu_valid = (ai < 3); alu_wen = 1'b1;
        alu_rd = RA_W'(24 + ai); alu_data = 64'h200 + 64'(ai);
        lsu_valid = (li < 4); lsu_rd = RA_W'(20 + li);
        lsu_funct3 = F3_LD; lsu_addr_lo = 3'd0; lsu_rdata = 64'h100 + 64'(li);
        #1;
        check($sformatf("drain%0d.alu_ready", c), alu_ready, dr_ar[c]);
        check($sformatf("drain%0d.lsu_ready", c), lsu_ready, dr_lr[c]);
        a_fire = alu_valid && alu_ready;
        l_fire = lsu_valid && lsu_ready;
        @(posedge clk); #1;
        if (a_fire) ai++;
        if (l_fire) li++;
        check_wb($sformatf("drain%0d", c), dr_rd[c] != '0, dr_rd[c], dr_dat[c], dr_rd[c] != '0, 1'b0);
      end
      idle_inputs();
    end

    // Reset with two queued ALU results: they must never be written.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = RA_W'(1 + c); alu_data = 64'h300 + 64'(c);
      lsu_valid = 1'b1; lsu_rd = RA_W'(28 + c); lsu_funct3 = F3_LD; lsu_rdata = 64'h400 + 64'(c);
      @(posedge clk); #1;
      check_wb($sformatf("qrst_fill%0d", c), 1'b1, RA_W'(28 + c), 64'h400 + 64'(c), 1'b1, 1'b0);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    check_wb("qrst_hold", 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_wb($sformatf("qrst_after%0d", c), 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
      check($sformatf("qrst_after%0d.alu_ready", c), alu_ready, 1'b1);
      check($sformatf("qrst_after%0d.lsu_ready", c), lsu_ready, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
